// File: rtl/control_sequencer.sv
// Hardwired T0..T7 step sequencer for the Mini-SRC datapath: fetch, decode and
// execute, with a bounded memory handshake and sticky halt / memory-error freeze.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        in_clr_n,
    input  logic        in_run,
    input  logic [31:0] in_ir,
    input  logic        in_mem_ready,
    output logic        out_reg_clear,
    output logic [3:0]  out_regfile_location,
    output logic [3:0]  out_alu_opcode,
    output logic        out_mdr_select,
    output logic        out_inc_pc,
    output logic        out_BAout,
    output logic [8:0]  out_read_sel,
    output logic [9:0]  out_write_en,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic [2:0]  out_step,
    output logic        out_halted,
    output logic        out_mem_err
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);

    // Bus sources {c,inport,mdr,pc,zlo,zhi,lo,hi,regfile}
    localparam logic [8:0] RS_C   = 9'h100;
    localparam logic [8:0] RS_IN  = 9'h080;
    localparam logic [8:0] RS_MDR = 9'h040;
    localparam logic [8:0] RS_PC  = 9'h020;
    localparam logic [8:0] RS_ZLO = 9'h010;
    localparam logic [8:0] RS_ZHI = 9'h008;
    localparam logic [8:0] RS_LO  = 9'h004;
    localparam logic [8:0] RS_HI  = 9'h002;
    localparam logic [8:0] RS_RF  = 9'h001;

    // Register write enables {outport,mar,y,ir,mdr,pc,z,lo,hi,regfile}
    localparam logic [9:0] WE_OUT = 10'h200;
    localparam logic [9:0] WE_MAR = 10'h100;
    localparam logic [9:0] WE_Y   = 10'h080;
    localparam logic [9:0] WE_IR  = 10'h040;
    localparam logic [9:0] WE_MDR = 10'h020;
    localparam logic [9:0] WE_PC  = 10'h010;
    localparam logic [9:0] WE_Z   = 10'h008;
    localparam logic [9:0] WE_LO  = 10'h004;
    localparam logic [9:0] WE_HI  = 10'h002;
    localparam logic [9:0] WE_RF  = 10'h001;

    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
        T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
    } step_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_RTYPE, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI,
        CL_ST, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_JR, CL_HALT
    } class_t;

    step_t          r_step;
    step_t          w_next;
    logic           r_halted;
    logic           r_memErr;
    logic [CW-1:0]  r_waitCnt;

    logic [4:0]     w_op;
    logic [3:0]     w_ra;
    logic [3:0]     w_rb;
    logic [3:0]     w_rc;
    class_t         w_class;
    logic [3:0]     w_alu;
    logic           w_unusedIrBits;

    logic [3:0]     w_loc;
    logic [3:0]     w_aluOut;
    logic           w_mdrSel;
    logic           w_incPc;
    logic           w_baOut;
    logic [8:0]     w_readSel;
    logic [9:0]     w_writeEn;
    logic           w_memRead;
    logic           w_memWrite;
    logic           w_waitRead;
    logic           w_waitWrite;
    logic           w_setHalt;
    logic           w_setErr;
    logic           w_cntInc;
    logic           w_cntClr;

    assign w_op  = in_ir[31:27];
    assign w_ra  = in_ir[26:23];
    assign w_rb  = in_ir[22:19];
    assign w_rc  = in_ir[18:15];
    assign w_unusedIrBits = ^in_ir[14:0];

    // Opcode map: ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, ror 7, rol 8, shr 9,
    // shl 10, addi 11, andi 12, ori 13, mul 14, div 15, neg 16, not 17, jr 19,
    // in 21, out 22, mfhi 23, mflo 24, nop 25, halt 26; everything else behaves as nop.
    always_comb begin
        w_class = CL_NOP;
        w_alu   = 4'd0;
        case (w_op)
            5'd0:  w_class = CL_LD;
            5'd1:  w_class = CL_LDI;
            5'd2:  w_class = CL_ST;
            5'd3:  begin w_class = CL_RTYPE;  w_alu = 4'd0;  end
            5'd4:  begin w_class = CL_RTYPE;  w_alu = 4'd1;  end
            5'd5:  begin w_class = CL_RTYPE;  w_alu = 4'd2;  end
            5'd6:  begin w_class = CL_RTYPE;  w_alu = 4'd3;  end
            5'd7:  begin w_class = CL_RTYPE;  w_alu = 4'd6;  end
            5'd8:  begin w_class = CL_RTYPE;  w_alu = 4'd7;  end
            5'd9:  begin w_class = CL_RTYPE;  w_alu = 4'd4;  end
            5'd10: begin w_class = CL_RTYPE;  w_alu = 4'd5;  end
            5'd11: begin w_class = CL_IMM;    w_alu = 4'd0;  end
            5'd12: begin w_class = CL_IMM;    w_alu = 4'd2;  end
            5'd13: begin w_class = CL_IMM;    w_alu = 4'd3;  end
            5'd14: begin w_class = CL_MULDIV; w_alu = 4'd8;  end
            5'd15: begin w_class = CL_MULDIV; w_alu = 4'd9;  end
            5'd16: begin w_class = CL_UNARY;  w_alu = 4'd10; end
            5'd17: begin w_class = CL_UNARY;  w_alu = 4'd11; end
            5'd19: w_class = CL_JR;
            5'd21: w_class = CL_IN;
            5'd22: w_class = CL_OUT;
            5'd23: w_class = CL_MFHI;
            5'd24: w_class = CL_MFLO;
            5'd26: w_class = CL_HALT;
            default: w_class = CL_NOP;
        endcase
    end

    // Next step and control word; a frozen sequencer (halt or memory error) drives nothing.
    always_comb begin
        w_next      = r_step;
        w_loc       = 4'd0;
        w_aluOut    = 4'd0;
        w_mdrSel    = 1'b0;
        w_incPc     = 1'b0;
        w_baOut     = 1'b0;
        w_readSel   = 9'd0;
        w_writeEn   = 10'd0;
        w_memRead   = 1'b0;
        w_memWrite  = 1'b0;
        w_waitRead  = 1'b0;
        w_waitWrite = 1'b0;
        w_setHalt   = 1'b0;
        w_setErr    = 1'b0;
        w_cntInc    = 1'b0;
        w_cntClr    = 1'b0;

        if (!(r_halted || r_memErr)) begin
            case (r_step)
                T0: begin
                    if (in_run) begin
                        w_readSel = RS_PC;
                        w_writeEn = WE_MAR | WE_PC;
                        w_incPc   = 1'b1;
                        w_next    = T1;
                    end
                end
                T1: begin
                    w_waitRead = 1'b1;
                    w_next     = T2;
                end
                T2: begin
                    w_readSel = RS_MDR;
                    w_writeEn = WE_IR;
                    w_next    = T3;
                end
                T3: begin
                    w_next = T4;
                    case (w_class)
                        CL_RTYPE, CL_IMM, CL_MULDIV: begin
                            w_loc = w_rb; w_readSel = RS_RF; w_writeEn = WE_Y;
                        end
                        CL_UNARY: begin
                            w_loc = w_rb; w_readSel = RS_RF; w_aluOut = w_alu; w_writeEn = WE_Z;
                        end
                        CL_LD, CL_LDI, CL_ST: begin
                            w_loc = w_rb; w_baOut = 1'b1; w_writeEn = WE_Y;
                        end
                        CL_IN: begin
                            w_loc = w_ra; w_readSel = RS_IN; w_writeEn = WE_RF; w_next = T0;
                        end
                        CL_OUT: begin
                            w_loc = w_ra; w_readSel = RS_RF; w_writeEn = WE_OUT; w_next = T0;
                        end
                        CL_MFHI: begin
                            w_loc = w_ra; w_readSel = RS_HI; w_writeEn = WE_RF; w_next = T0;
                        end
                        CL_MFLO: begin
                            w_loc = w_ra; w_readSel = RS_LO; w_writeEn = WE_RF; w_next = T0;
                        end
                        CL_JR: begin
                            w_loc = w_ra; w_readSel = RS_RF; w_writeEn = WE_PC; w_next = T0;
                        end
                        CL_HALT: begin
                            w_setHalt = 1'b1; w_next = T3;
                        end
                        default: w_next = T0;
                    endcase
                end
                T4: begin
                    w_next = T5;
                    case (w_class)
                        CL_RTYPE, CL_MULDIV: begin
                            w_loc = w_rc; w_readSel = RS_RF; w_aluOut = w_alu; w_writeEn = WE_Z;
                        end
                        CL_IMM, CL_LD, CL_LDI, CL_ST: begin
                            w_readSel = RS_C; w_aluOut = w_alu; w_writeEn = WE_Z;
                        end
                        CL_UNARY: begin
                            w_loc = w_ra; w_readSel = RS_ZLO; w_writeEn = WE_RF; w_next = T0;
                        end
                        default: w_next = T0;
                    endcase
                end
                T5: begin
                    w_next = T0;
                    case (w_class)
                        CL_RTYPE, CL_IMM, CL_LDI: begin
                            w_loc = w_ra; w_readSel = RS_ZLO; w_writeEn = WE_RF;
                        end
                        CL_MULDIV: begin
                            w_readSel = RS_ZLO; w_writeEn = WE_LO; w_next = T6;
                        end
                        CL_LD, CL_ST: begin
                            w_readSel = RS_ZLO; w_writeEn = WE_MAR; w_next = T6;
                        end
                        default: w_next = T0;
                    endcase
                end
                T6: begin
                    w_next = T0;
                    case (w_class)
                        CL_MULDIV: begin
                            w_readSel = RS_ZHI; w_writeEn = WE_HI;
                        end
                        CL_LD: begin
                            w_waitRead = 1'b1; w_next = T7;
                        end
                        CL_ST: begin
                            w_loc = w_ra; w_readSel = RS_RF; w_writeEn = WE_MDR; w_next = T7;
                        end
                        default: w_next = T0;
                    endcase
                end
                T7: begin
                    w_next = T0;
                    case (w_class)
                        CL_LD: begin
                            w_loc = w_ra; w_readSel = RS_MDR; w_writeEn = WE_RF;
                        end
                        CL_ST: w_waitWrite = 1'b1;
                        default: w_next = T0;
                    endcase
                end
                default: w_next = T0;
            endcase

            // Shared handshake: hold the request and the step until memory answers.
            if (w_waitRead || w_waitWrite) begin
                w_memRead  = w_waitRead;
                w_memWrite = w_waitWrite;
                w_mdrSel   = w_waitRead;
                if (in_mem_ready) begin
                    w_cntClr = 1'b1;
                    if (w_waitRead) begin
                        w_writeEn = WE_MDR;
                    end
                end else begin
                    w_next = r_step;
                    if (TIMEOUT_EN && (r_waitCnt == CNT_LAST)) begin
                        w_setErr = 1'b1;
                    end else begin
                        w_cntInc = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!in_clr_n) begin
            r_step    <= T0;
            r_halted  <= 1'b0;
            r_memErr  <= 1'b0;
            r_waitCnt <= '0;
        end else begin
            r_step <= w_next;
            if (w_setHalt) begin
                r_halted <= 1'b1;
            end
            if (w_setErr) begin
                r_memErr <= 1'b1;
            end
            if (w_cntClr) begin
                r_waitCnt <= '0;
            end else if (w_cntInc) begin
                r_waitCnt <= r_waitCnt + CW'(1);
            end
        end
    end

    // Reset is visible combinationally so the datapath clears in the same cycle.
    always_comb begin
        out_reg_clear        = ~in_clr_n;
        out_regfile_location = in_clr_n ? w_loc      : 4'd0;
        out_alu_opcode       = in_clr_n ? w_aluOut   : 4'd0;
        out_mdr_select       = in_clr_n & w_mdrSel;
        out_inc_pc           = in_clr_n & w_incPc;
        out_BAout            = in_clr_n & w_baOut;
        out_read_sel         = in_clr_n ? w_readSel  : 9'd0;
        out_write_en         = in_clr_n ? w_writeEn  : 10'd0;
        out_mem_read         = in_clr_n & w_memRead;
        out_mem_write        = in_clr_n & w_memWrite;
        out_step             = in_clr_n ? r_step     : 3'd0;
        out_halted           = in_clr_n & r_halted;
        out_mem_err          = in_clr_n & r_memErr;
    end

endmodule
